// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter that snoops CPU stores into a byte FIFO
// and exposes a polled status word (overflow, busy, fifo_full) on the read mux.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        sel,
    output logic        tx,
    output logic        fifo_full,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_sample;
    logic [2:0]    r_bit;
    logic          w_hit_data, w_hit_stat, w_empty, w_last, w_pop, w_push_req, w_push;
    logic          w_unused;

    assign w_hit_data = DataAdr[31:2] == BASE_ADDR[31:2];
    assign w_hit_stat = DataAdr[31:2] == STAT_ADDR[31:2];
    assign sel        = w_hit_data | w_hit_stat;
    assign w_empty    = r_count == '0;
    assign fifo_full  = r_count == (AW+1)'(FIFO_DEPTH);
    assign busy       = !w_empty || r_state != IDLE;
    assign w_last     = r_sample == LAST;
    // A pop happens from IDLE or on the final STOP cycle, giving gapless back-to-back frames.
    assign w_pop      = !w_empty && (r_state == IDLE || (r_state == STOP && w_last));
    assign w_push_req = MemWrite && w_hit_data;
    assign w_push     = w_push_req && (!fifo_full || w_pop);
    assign RdData     = w_hit_stat ? {29'b0, r_ovf, busy, fifo_full} :
                        w_hit_data ? {24'b0, 8'(r_count)} : '0;
    assign w_unused   = ^{DataAdr[1:0], WriteData[31:8]};

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= WriteData[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push_req && !w_push) r_ovf <= 1'b1;
            else if (MemWrite && w_hit_stat && WriteData[2]) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            tx       <= 1'b1;
            r_shift  <= '0;
            r_sample <= '0;
            r_bit    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    tx <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd];
                        r_state  <= START;
                        tx       <= 1'b0;
                        r_sample <= '0;
                    end
                end
                START: begin
                    r_sample <= w_last ? '0 : r_sample + 1'b1;
                    if (w_last) begin
                        r_state <= DATA;
                        tx      <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                    end
                end
                DATA: begin
                    r_sample <= w_last ? '0 : r_sample + 1'b1;
                    if (w_last) begin
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            tx      <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                STOP: begin
                    r_sample <= w_last ? '0 : r_sample + 1'b1;
                    if (w_last) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd];
                            r_state <= START;
                            tx      <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stores with a serial-receiver monitor that checks each frame
// against a queue of expected bytes, plus direct checks of status, decode and timing.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h200;
    logic [31:0] WriteData = '0;
    logic [31:0] RdData;
    logic        sel, tx, fifo_full, busy;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int prev_start = 0, last_start = 0, n_frames = 0;
    logic [7:0] exp_q[$];

    mmio_uart_tx #(.BASE_ADDR(32'h100), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .RdData(RdData), .sel(sel), .tx(tx),
        .fifo_full(fifo_full), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        @(negedge clk);
    endtask

    task automatic idle_bus();
        MemWrite = 1'b0;
        DataAdr = 32'h200;
        WriteData = '0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        DataAdr = a;
        #1 check(name, RdData, exp);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", {31'b0, busy}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Serial receiver: mid-bit sampling; frames disturbed by reset are discarded.
    initial begin
        logic [7:0] b;
        logic ok, s0, s9;
        b = '0; s0 = 1'b0; s9 = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                prev_start = last_start;
                last_start = cyc;
                ok = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? CPB / 2 : CPB) begin
                        @(negedge clk);
                        if (reset) ok = 1'b0;
                    end
                    if (k == 0) s0 = tx;
                    else if (k == 9) s9 = tx;
                    else b[k-1] = tx;
                end
                if (ok) begin
                    n_frames++;
                    check("start_bit", {31'b0, s0}, 32'd0);
                    check("stop_bit", {31'b0, s9}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %h expected none", b);
                    end else begin
                        check("rx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        logic bad;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Reset state and idle line
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_full", {31'b0, fifo_full}, 32'd0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("idle_20", {31'b0, bad}, 32'd0);
        read_chk("rd_nohit", 32'h200, 32'd0);
        check("sel_nohit", {31'b0, sel}, 32'd0);

        // Single frame 0xA5
        exp_q.push_back(8'hA5);
        store(32'h100, 32'hFFFF_FFA5);
        idle_bus();
        check("tx_before_fall", {31'b0, tx}, 32'd1);
        @(negedge clk);
        check("tx_fall", {31'b0, tx}, 32'd0);
        repeat (39) @(negedge clk);
        check("busy_last_cycle", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("busy_done", {31'b0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        // Back-to-back frames
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        store(32'h100, 32'h55);
        store(32'h100, 32'h0F);
        idle_bus();
        bad = 1'b0;
        repeat (80) begin
            if (busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        check("busy_b2b", {31'b0, bad}, 32'd0);
        wait_idle(20);
        check("b2b_gap", last_start - prev_start, 32'd40);

        // Overflow: 0x06 dropped
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back(8'(i));
            store(32'h100, 32'(i));
        end
        idle_bus();
        read_chk("status_full_ovf", 32'h104, 32'h7);
        check("sel_status", {31'b0, sel}, 32'd1);
        read_chk("txdata_count4", 32'h100, 32'h4);
        repeat (5) @(negedge clk);
        read_chk("status_sticky", 32'h104, 32'h7);
        store(32'h104, 32'h4);
        idle_bus();
        read_chk("status_cleared", 32'h104, 32'h3);
        wait_idle(300);
        read_chk("status_after_drain", 32'h104, 32'h0);

        // Reset during DATA bit 3 of 0x33 (bit3 = 0)
        store(32'h100, 32'h33);
        idle_bus();
        repeat (18) @(negedge clk);
        check("tx_bit3_low", {31'b0, tx}, 32'd0);
        #1 reset = 1'b1;
        #1 check("tx_async_reset", {31'b0, tx}, 32'd1);
        check("busy_async_reset", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("quiet_after_reset", {31'b0, bad}, 32'd0);

        // Decode
        store(32'h108, 32'h11);
        store(32'h0FC, 32'h22);
        idle_bus();
        read_chk("no_push_count", 32'h100, 32'h0);
        check("no_push_busy", {31'b0, busy}, 32'd0);
        read_chk("rd_108", 32'h108, 32'h0);
        check("sel_108", {31'b0, sel}, 32'd0);
        DataAdr = 32'h0FC;
        #1 check("sel_0fc", {31'b0, sel}, 32'd0);
        DataAdr = 32'h103;
        #1 check("sel_103", {31'b0, sel}, 32'd1);
        exp_q.push_back(8'h5A);
        store(32'h103, 32'h5A);
        idle_bus();
        read_chk("push_103_count", 32'h100, 32'h1);
        wait_idle(80);

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("frame_count", n_frames, 32'd9);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
